// File: rtl/push_gen_pkg.sv
// Shared definitions for the FIFO push-side generator and its pop-side peers:
// FSM encoding, pattern geometry, counter width and pattern-bit lookup.
package push_gen_pkg;

  localparam int PATTERN_W = 64;
  localparam int IDX_W     = 6;
  localparam int CNT_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Pattern is consumed MSB first. For a 6-bit index, ~idx == 63 - idx.
  function automatic logic pattern_bit(input logic [PATTERN_W-1:0] pattern,
                                       input logic [IDX_W-1:0]     idx);
    return pattern[~idx];
  endfunction

endpackage

// File: rtl/push_gen_if.sv
// Write-side FIFO handshake: push strobe and data toward the FIFO, full flag back.
interface push_gen_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  pushOut;
  logic [DATA_WIDTH-1:0] dataOut;
  logic                  fullIn;

  modport master (output pushOut, output dataOut, input fullIn);
  modport slave  (input  pushOut, input  dataOut, output fullIn);
endinterface

// File: rtl/push_gen.sv
// Push-side stimulus generator: walks a 64-bit request pattern, retries or
// drops requests that meet a full FIFO, emits an incrementing data sequence
// and reports push/drop counts plus a done flag.
module push_gen
  import push_gen_pkg::*;
#(
  parameter int                   DATA_WIDTH   = 8,
  parameter logic [PATTERN_W-1:0] PUSH_ORDER   = 64'hFFFF_0000_0000_0000,
  parameter int                   SEED         = 0,
  parameter int                   DATA_STEP    = 1,
  parameter int                   DROP_ON_FULL = 0,
  parameter int                   LOOP         = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startIn,
  push_gen_if.master       fifo,
  output logic [CNT_W-1:0] pushCount,
  output logic [CNT_W-1:0] dropCount,
  output logic             done
);

  localparam logic [6:0] PEND_MAX = 7'd127;

  state_t                r_state;
  logic [IDX_W-1:0]      r_idx;
  logic [6:0]            r_pend;
  logic [DATA_WIDTH-1:0] r_data;
  logic [CNT_W-1:0]      r_push_cnt;
  logic [CNT_W-1:0]      r_drop_cnt;
  logic                  r_done;

  logic                  w_active;
  logic                  w_bit;
  logic                  w_push;
  logic                  w_drop;
  logic [6:0]            w_pend_next;

  // Request arbitration: decide this cycle's push, drop and next pending count.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    w_drop      = 1'b0;
    w_pend_next = r_pend;
    w_active    = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    w_bit       = (r_state == ST_RUN) && pattern_bit(PUSH_ORDER, r_idx);
    w_push      = w_active && (w_bit || (r_pend != '0)) && !fifo.fullIn;

    if (DROP_ON_FULL != 0) begin
      w_drop = w_bit && fifo.fullIn;
    end else if (w_bit && !w_push) begin
      // New request blocked by full: park it, or lose it if the backlog is saturated.
      if (r_pend == PEND_MAX) w_drop = 1'b1;
      else                    w_pend_next = r_pend + 7'd1;
    end else if (!w_bit && w_push) begin
      w_pend_next = r_pend - 7'd1;
    end
  end

  // FSM, pattern index, pending backlog, data generator and counters.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every register samples pre-edge values, independent of statement order.
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_pend     <= '0;
      r_data     <= DATA_WIDTH'(SEED);
      r_push_cnt <= '0;
      r_drop_cnt <= '0;
      r_done     <= 1'b0;
    end else begin
      if (w_push) begin
        r_data     <= r_data + DATA_WIDTH'(DATA_STEP);
        r_push_cnt <= r_push_cnt + CNT_W'(1);
      end
      if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + CNT_W'(1);

      case (r_state)
        ST_IDLE: begin
          if (startIn) begin
            r_state <= ST_RUN;
            r_idx   <= '0;
          end
        end
        ST_RUN: begin
          r_idx  <= r_idx + IDX_W'(1);
          r_pend <= w_pend_next;
          if ((r_idx == '1) && (LOOP == 0)) begin
            if (w_pend_next != '0) begin
              r_state <= ST_DRAIN;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          r_pend <= w_pend_next;
          if (w_pend_next == '0) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: ;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign fifo.pushOut = w_push;
  assign fifo.dataOut = r_data;
  assign pushCount    = r_push_cnt;
  assign dropCount    = r_drop_cnt;
  assign done         = r_done;

endmodule

// File: tb/tb_push_gen.sv
// Scoreboard bench for push_gen: stimulus queues expected push data, per-DUT
// monitors pop and compare whenever a push strobe is seen.
module tb_push_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A: default params. B: drop on full. C: all-ones pattern. D: looping, wrapped data.
  logic rst_a, rst_b, rst_c, rst_d;
  logic start_a, start_b, start_c, start_d;
  logic [15:0] pc_a, pc_b, pc_c, pc_d;
  logic [15:0] dc_a, dc_b, dc_c, dc_d;
  logic done_a, done_b, done_c, done_d;

  push_gen_if #(.DATA_WIDTH(8)) if_a ();
  push_gen_if #(.DATA_WIDTH(8)) if_b ();
  push_gen_if #(.DATA_WIDTH(8)) if_c ();
  push_gen_if #(.DATA_WIDTH(8)) if_d ();

  push_gen #(.DATA_WIDTH(8)) dut_a (
    .clk(clk), .reset(rst_a), .startIn(start_a), .fifo(if_a),
    .pushCount(pc_a), .dropCount(dc_a), .done(done_a));

  push_gen #(.DATA_WIDTH(8), .DROP_ON_FULL(1)) dut_b (
    .clk(clk), .reset(rst_b), .startIn(start_b), .fifo(if_b),
    .pushCount(pc_b), .dropCount(dc_b), .done(done_b));

  push_gen #(.DATA_WIDTH(8), .PUSH_ORDER(64'hFFFF_FFFF_FFFF_FFFF)) dut_c (
    .clk(clk), .reset(rst_c), .startIn(start_c), .fifo(if_c),
    .pushCount(pc_c), .dropCount(dc_c), .done(done_c));

  push_gen #(.DATA_WIDTH(8), .SEED(8'hF8), .DATA_STEP(4), .LOOP(1)) dut_d (
    .clk(clk), .reset(rst_d), .startIn(start_d), .fifo(if_d),
    .pushCount(pc_d), .dropCount(dc_d), .done(done_d));

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic [7:0] q_c[$];
  logic [7:0] q_d[$];

  // Monitors: every observed push must match the oldest expected data value.
  always @(negedge clk) begin
    logic [7:0] exp;
    if (if_a.pushOut === 1'b1) begin
      if (q_a.size() > 0) begin
        exp = q_a.pop_front();
        check("a_data", 32'(if_a.dataOut), 32'(exp));
      end else check("a_extra_push", 32'(if_a.pushOut), 32'd0);
    end
  end

  always @(negedge clk) begin
    logic [7:0] exp;
    if (if_b.pushOut === 1'b1) begin
      if (q_b.size() > 0) begin
        exp = q_b.pop_front();
        check("b_data", 32'(if_b.dataOut), 32'(exp));
      end else check("b_extra_push", 32'(if_b.pushOut), 32'd0);
    end
  end

  always @(negedge clk) begin
    logic [7:0] exp;
    if (if_c.pushOut === 1'b1) begin
      if (q_c.size() > 0) begin
        exp = q_c.pop_front();
        check("c_data", 32'(if_c.dataOut), 32'(exp));
      end else check("c_extra_push", 32'(if_c.pushOut), 32'd0);
    end
  end

  always @(negedge clk) begin
    logic [7:0] exp;
    if (if_d.pushOut === 1'b1) begin
      if (q_d.size() > 0) begin
        exp = q_d.pop_front();
        check("d_data", 32'(if_d.dataOut), 32'(exp));
      end else check("d_extra_push", 32'(if_d.pushOut), 32'd0);
    end
  end

  // Checks DUT A is in its reset state.
  task automatic check_a_reset(input string tag);
    @(negedge clk);
    check({tag, "_push"},  32'(if_a.pushOut), 32'd0);
    check({tag, "_data"},  32'(if_a.dataOut), 32'h00);
    check({tag, "_pcnt"},  32'(pc_a), 32'd0);
    check({tag, "_dcnt"},  32'(dc_a), 32'd0);
    check({tag, "_done"},  32'(done_a), 32'd0);
  endtask

  // Plain pass on DUT A with fullIn low: 16 pushes 0x00..0x0F, done 64 cycles after RUN entry.
  task automatic run_a_plain(input string tag);
    for (int i = 0; i < 16; i++) q_a.push_back(8'(i));
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      check({tag, "_push"}, 32'(if_a.pushOut), 32'(k < 16));
      check({tag, "_done_low"}, 32'(done_a), 32'd0);
      tick();
    end
    @(negedge clk);
    check({tag, "_done"}, 32'(done_a), 32'd1);
    check({tag, "_push_after"}, 32'(if_a.pushOut), 32'd0);
    check({tag, "_pcnt"}, 32'(pc_a), 32'd16);
    check({tag, "_dcnt"}, 32'(dc_a), 32'd0);
    check({tag, "_queue"}, 32'(q_a.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time 200000 reached, expected finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; start_d = 1'b0;
    if_a.fullIn = 1'b0; if_b.fullIn = 1'b0; if_c.fullIn = 1'b0; if_d.fullIn = 1'b0;
    repeat (2) tick();
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1;

    // Reset state, including seed truncation on D.
    check_a_reset("rst_a");
    check("rst_d_data", 32'(if_d.dataOut), 32'hF8);
    check("rst_c_done", 32'(done_c), 32'd0);
    tick();

    // 1: default pattern, no backpressure.
    run_a_plain("t1");

    // 2: full for the first 4 pattern cycles; pushes deferred (pend 4), idx 4..19 push.
    tick();
    rst_a = 1'b0;
    tick();
    rst_a = 1'b1;
    check_a_reset("t2_rst");
    tick();
    for (int i = 0; i < 16; i++) q_a.push_back(8'(i));
    start_a = 1'b1;
    if_a.fullIn = 1'b1;
    tick();
    start_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t2_push_full", 32'(if_a.pushOut), 32'd0);
      tick();
    end
    if_a.fullIn = 1'b0;
    for (int k = 4; k < 64; k++) begin
      @(negedge clk);
      check("t2_push", 32'(if_a.pushOut), 32'(k < 20));
      tick();
    end
    @(negedge clk);
    check("t2_done", 32'(done_a), 32'd1);
    check("t2_pcnt", 32'(pc_a), 32'd16);
    check("t2_dcnt", 32'(dc_a), 32'd0);
    check("t2_queue", 32'(q_a.size()), 32'd0);
    tick();

    // 3: drop on full; the 4 blocked requests are lost.
    for (int i = 0; i < 12; i++) q_b.push_back(8'(i));
    start_b = 1'b1;
    if_b.fullIn = 1'b1;
    tick();
    start_b = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t3_push_full", 32'(if_b.pushOut), 32'd0);
      tick();
    end
    if_b.fullIn = 1'b0;
    for (int k = 4; k < 64; k++) begin
      @(negedge clk);
      check("t3_push", 32'(if_b.pushOut), 32'(k < 16));
      tick();
    end
    @(negedge clk);
    check("t3_done", 32'(done_b), 32'd1);
    check("t3_pcnt", 32'(pc_b), 32'd12);
    check("t3_dcnt", 32'(dc_b), 32'd4);
    check("t3_queue", 32'(q_b.size()), 32'd0);
    tick();

    // 4: all-ones pattern held off by full; 64 pending requests drain back-to-back.
    if_c.fullIn = 1'b1;
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      check("t4_push_full", 32'(if_c.pushOut), 32'd0);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t4_drain_wait", 32'(done_c), 32'd0);
      tick();
    end
    for (int i = 0; i < 64; i++) q_c.push_back(8'(i));
    if_c.fullIn = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      check("t4_push", 32'(if_c.pushOut), 32'd1);
      tick();
    end
    @(negedge clk);
    check("t4_done", 32'(done_c), 32'd1);
    check("t4_push_after", 32'(if_c.pushOut), 32'd0);
    check("t4_pcnt", 32'(pc_c), 32'd64);
    check("t4_dcnt", 32'(dc_c), 32'd0);
    check("t4_queue", 32'(q_c.size()), 32'd0);
    tick();

    // 5: reset while a retry is pending; state clears, pending is not a drop, replay from SEED.
    rst_a = 1'b0;
    tick();
    rst_a = 1'b1;
    tick();
    q_a.push_back(8'h00);
    if_a.fullIn = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t5_push_full", 32'(if_a.pushOut), 32'd0);
      tick();
    end
    if_a.fullIn = 1'b0;
    @(negedge clk);
    check("t5_push_once", 32'(if_a.pushOut), 32'd1);
    tick();
    if_a.fullIn = 1'b1;
    rst_a = 1'b0;
    @(negedge clk);
    check("t5_pre_pcnt", 32'(pc_a), 32'd1);
    check("t5_pre_data", 32'(if_a.dataOut), 32'h01);
    tick();
    check_a_reset("t5_rst");
    tick();
    rst_a = 1'b1;
    if_a.fullIn = 1'b0;
    run_a_plain("t5_replay");
    tick();

    // 6: looping pattern with wrapping data; done never rises.
    for (int i = 0; i < 48; i++) q_d.push_back(8'(8'hF8 + 4 * i));
    start_d = 1'b1;
    tick();
    start_d = 1'b0;
    for (int k = 0; k < 192; k++) begin
      @(negedge clk);
      check("t6_push", 32'(if_d.pushOut), 32'((k % 64) < 16));
      check("t6_done_low", 32'(done_d), 32'd0);
      if (k == 191) begin
        check("t6_pcnt", 32'(pc_d), 32'd48);
        check("t6_dcnt", 32'(dc_d), 32'd0);
        rst_d = 1'b0;
      end
      tick();
    end
    @(negedge clk);
    check("t6_rst_push", 32'(if_d.pushOut), 32'd0);
    check("t6_rst_data", 32'(if_d.dataOut), 32'hF8);
    check("t6_rst_pcnt", 32'(pc_d), 32'd0);
    check("t6_queue", 32'(q_d.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
